// File: rtl/axi_lite_regbank_if.sv
// AXI4-Lite slave bus bundle for axi_lite_regbank: AW, W, B, AR and R channels.
// The master modport drives requests; the slave modport drives readies and responses.
`timescale 1ns/1ps
interface axi_lite_regbank_if #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0]   s_axi_awaddr;
  logic                s_axi_awvalid;
  logic                s_axi_awready;
  logic [DATA_W-1:0]   s_axi_wdata;
  logic [DATA_W/8-1:0] s_axi_wstrb;
  logic                s_axi_wvalid;
  logic                s_axi_wready;
  logic [1:0]          s_axi_bresp;
  logic                s_axi_bvalid;
  logic                s_axi_bready;
  logic [ADDR_W-1:0]   s_axi_araddr;
  logic                s_axi_arvalid;
  logic                s_axi_arready;
  logic [DATA_W-1:0]   s_axi_rdata;
  logic [1:0]          s_axi_rresp;
  logic                s_axi_rvalid;
  logic                s_axi_rready;

  modport master (
    output s_axi_awaddr, s_axi_awvalid, s_axi_wdata, s_axi_wstrb, s_axi_wvalid,
           s_axi_bready, s_axi_araddr, s_axi_arvalid, s_axi_rready,
    input  s_axi_awready, s_axi_wready, s_axi_bresp, s_axi_bvalid,
           s_axi_arready, s_axi_rdata, s_axi_rresp, s_axi_rvalid
  );

  modport slave (
    input  s_axi_awaddr, s_axi_awvalid, s_axi_wdata, s_axi_wstrb, s_axi_wvalid,
           s_axi_bready, s_axi_araddr, s_axi_arvalid, s_axi_rready,
    output s_axi_awready, s_axi_wready, s_axi_bresp, s_axi_bvalid,
           s_axi_arready, s_axi_rdata, s_axi_rresp, s_axi_rvalid
  );
endinterface

// File: rtl/axi_lite_regbank.sv
// AXI4-Lite register bank: NUM_REGS byte-strobed registers, independent AW/W slots, registered responses.
// Define AXIL_REGBANK_DECERR_EN to answer out-of-range accesses with DECERR instead of SLVERR.
`timescale 1ns/1ps
module axi_lite_regbank #(
  parameter int                ADDR_W    = 9,
  parameter int                DATA_W    = 32,
  parameter int                NUM_REGS  = 4,
  parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
  input  logic                         clk,
  input  logic                         s_axi_aresetn,
  axi_lite_regbank_if.slave            s_axi,
  output logic [NUM_REGS*DATA_W-1:0]   regs_o,
  output logic [NUM_REGS-1:0]          wr_pulse_o
);

  localparam int          STRB_W     = DATA_W / 8;
  localparam int          IDX_W      = ADDR_W - 2;
  localparam logic [31:0] NUM_REGS_U = 32'(NUM_REGS);
  localparam logic [1:0]  RESP_OKAY  = 2'b00;
`ifdef AXIL_REGBANK_DECERR_EN
  localparam logic [1:0]  RESP_ERR   = 2'b11;
`else
  localparam logic [1:0]  RESP_ERR   = 2'b10;
`endif

  function automatic logic idx_in_range(input logic [IDX_W-1:0] idx);
    return {{(32-IDX_W){1'b0}}, idx} < NUM_REGS_U;
  endfunction

  function automatic logic [DATA_W-1:0] merge_bytes(input logic [DATA_W-1:0] old_val,
                                                    input logic [DATA_W-1:0] new_val,
                                                    input logic [STRB_W-1:0] strb);
    logic [DATA_W-1:0] res;
    res = old_val;
    for (int b = 0; b < STRB_W; b++)
      if (strb[b]) res[b*8 +: 8] = new_val[b*8 +: 8];
    return res;
  endfunction

  logic [DATA_W-1:0] regs [NUM_REGS];

  logic              aw_full, w_full;
  logic [IDX_W-1:0]  aw_idx;
  logic [DATA_W-1:0] w_data;
  logic [STRB_W-1:0] w_strb;

  logic              awready, wready, arready;
  logic              bvalid, rvalid;
  logic [1:0]        bresp, rresp;
  logic [DATA_W-1:0] rdata;
  logic [NUM_REGS-1:0] wr_pulse;

  logic              aw_hs, w_hs, ar_hs, b_hs, r_hs, commit;
  logic              aw_full_nx, w_full_nx, bvalid_nx, rvalid_nx;
  logic [IDX_W-1:0]  ar_idx;
  logic [DATA_W-1:0] rd_val;
  logic [NUM_REGS-1:0] pulse_nx;
  logic              unused_addr_bits;

  assign aw_hs  = s_axi.s_axi_awvalid && awready;
  assign w_hs   = s_axi.s_axi_wvalid && wready;
  assign ar_hs  = s_axi.s_axi_arvalid && arready;
  assign b_hs   = bvalid && s_axi.s_axi_bready;
  assign r_hs   = rvalid && s_axi.s_axi_rready;
  // Both slots were filled on earlier edges, so the write lands one edge after the later handshake.
  assign commit = aw_full && w_full;
  assign ar_idx = s_axi.s_axi_araddr[ADDR_W-1:2];

  assign unused_addr_bits = ^{s_axi.s_axi_awaddr[1:0], s_axi.s_axi_araddr[1:0]};

  always_comb begin
    aw_full_nx = aw_full;
    w_full_nx  = w_full;
    bvalid_nx  = bvalid;
    rvalid_nx  = rvalid;
    if (commit) begin
      aw_full_nx = 1'b0;
      w_full_nx  = 1'b0;
      bvalid_nx  = 1'b1;
    end else begin
      if (aw_hs) aw_full_nx = 1'b1;
      if (w_hs)  w_full_nx  = 1'b1;
      if (b_hs)  bvalid_nx  = 1'b0;
    end
    if (r_hs)  rvalid_nx = 1'b0;
    if (ar_hs) rvalid_nx = 1'b1;
  end

  always_comb begin
    pulse_nx = '0;
    for (int i = 0; i < NUM_REGS; i++)
      if (commit && (aw_idx == IDX_W'(i))) pulse_nx[i] = 1'b1;
  end

  // Read mux: indices without a register fall through to zero.
  always_comb begin
    rd_val = '0;
    for (int i = 0; i < NUM_REGS; i++)
      if (ar_idx == IDX_W'(i)) rd_val = regs[i];
  end

  // Handshake and response state; readies are flops derived from the next-state slot/response flags.
  always_ff @(posedge clk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      aw_full  <= 1'b0;
      w_full   <= 1'b0;
      bvalid   <= 1'b0;
      rvalid   <= 1'b0;
      awready  <= 1'b0;
      wready   <= 1'b0;
      arready  <= 1'b0;
      bresp    <= 2'b00;
      rresp    <= 2'b00;
      rdata    <= '0;
      wr_pulse <= '0;
    end else begin
      aw_full  <= aw_full_nx;
      w_full   <= w_full_nx;
      bvalid   <= bvalid_nx;
      rvalid   <= rvalid_nx;
      awready  <= !aw_full_nx && !bvalid_nx;
      wready   <= !w_full_nx && !bvalid_nx;
      arready  <= !rvalid_nx;
      wr_pulse <= pulse_nx;
      if (commit)
        bresp <= idx_in_range(aw_idx) ? RESP_OKAY : RESP_ERR;
      if (ar_hs) begin
        rdata <= rd_val;
        rresp <= idx_in_range(ar_idx) ? RESP_OKAY : RESP_ERR;
      end
    end
  end

  // Slot payloads need no reset: they are only consumed while the matching full flag is set.
  always_ff @(posedge clk) begin
    if (aw_hs) aw_idx <= s_axi.s_axi_awaddr[ADDR_W-1:2];
    if (w_hs) begin
      w_data <= s_axi.s_axi_wdata;
      w_strb <= s_axi.s_axi_wstrb;
    end
  end

  // Register array; a same-edge read capture sees the pre-commit value through rd_val.
  always_ff @(posedge clk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= RESET_VAL;
    end else begin
      for (int i = 0; i < NUM_REGS; i++)
        if (pulse_nx[i]) regs[i] <= merge_bytes(regs[i], w_data, w_strb);
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) regs_o[i*DATA_W +: DATA_W] = regs[i];
  end

  assign wr_pulse_o            = wr_pulse;
  assign s_axi.s_axi_awready   = awready;
  assign s_axi.s_axi_wready    = wready;
  assign s_axi.s_axi_arready   = arready;
  assign s_axi.s_axi_bvalid    = bvalid;
  assign s_axi.s_axi_bresp     = bresp;
  assign s_axi.s_axi_rvalid    = rvalid;
  assign s_axi.s_axi_rresp     = rresp;
  assign s_axi.s_axi_rdata     = rdata;

endmodule

// File: tb/tb_axi_lite_regbank.sv
// Bench for axi_lite_regbank: directed scenarios plus randomized concurrent traffic,
// checked every cycle against a transaction-level model of the register bank.
`timescale 1ns/1ps
module tb_axi_lite_regbank;
  localparam int ADDR_W   = 9;
  localparam int DATA_W   = 32;
  localparam int NUM_REGS = 4;
  localparam int TMO      = 40;
`ifdef AXIL_REGBANK_DECERR_EN
  localparam logic [1:0] ERR = 2'b11;
`else
  localparam logic [1:0] ERR = 2'b10;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  axi_lite_regbank_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();
  logic [NUM_REGS*DATA_W-1:0] regs_o;
  logic [NUM_REGS-1:0]        wr_pulse_o;

  axi_lite_regbank #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .NUM_REGS(NUM_REGS), .RESET_VAL('0)) dut (
    .clk(clk), .s_axi_aresetn(rst_n), .s_axi(bus), .regs_o(regs_o), .wr_pulse_o(wr_pulse_o));

  int n_chk = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    n_chk++;
    n_fail++;
    $display("FAIL %s: timed out after %0d cycles (t=%0t)", name, TMO, $time);
  endtask

  // Model state: register contents, which write channels have been accepted, response expectations.
  logic [31:0] mregs [NUM_REGS];
  bit          aw_have, w_have;
  int          aw_idx, ridx;
  logic [31:0] w_d;
  logic [3:0]  w_s;
  bit          exp_awready, exp_wready, exp_arready, exp_bvalid, exp_rvalid;
  logic [1:0]  exp_bresp, exp_rresp;
  logic [31:0] exp_rdata;
  logic [3:0]  exp_pulse;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) mregs[i] = '0;
      aw_have = 0; w_have = 0;
      exp_awready = 0; exp_wready = 0; exp_arready = 0;
      exp_bvalid = 0; exp_rvalid = 0;
      exp_bresp = 0; exp_rresp = 0; exp_rdata = 0; exp_pulse = 0;
    end else begin
      exp_pulse = 0;
      if (exp_bvalid && bus.s_axi_bready) exp_bvalid = 0;
      if (exp_rvalid && bus.s_axi_rready) exp_rvalid = 0;
      if (exp_arready && bus.s_axi_arvalid) begin
        ridx = int'(bus.s_axi_araddr[8:2]);
        exp_rvalid = 1;
        exp_rdata = '0;
        exp_rresp = (ridx < NUM_REGS) ? 2'b00 : ERR;
        for (int i = 0; i < NUM_REGS; i++) if (i == ridx) exp_rdata = mregs[i];
      end
      if (aw_have && w_have) begin
        exp_bresp = (aw_idx < NUM_REGS) ? 2'b00 : ERR;
        for (int i = 0; i < NUM_REGS; i++)
          if (i == aw_idx) begin
            exp_pulse[i] = 1'b1;
            for (int b = 0; b < 4; b++) if (w_s[b]) mregs[i][b*8 +: 8] = w_d[b*8 +: 8];
          end
        aw_have = 0; w_have = 0; exp_bvalid = 1;
      end else begin
        if (exp_awready && bus.s_axi_awvalid) begin
          aw_have = 1; aw_idx = int'(bus.s_axi_awaddr[8:2]);
        end
        if (exp_wready && bus.s_axi_wvalid) begin
          w_have = 1; w_d = bus.s_axi_wdata; w_s = bus.s_axi_wstrb;
        end
      end
      exp_awready = !aw_have && !exp_bvalid;
      exp_wready  = !w_have && !exp_bvalid;
      exp_arready = !exp_rvalid;
    end
  end

  int         pulse_cnt = 0;
  logic [3:0] last_pulse = '0;

  always @(negedge clk) begin
    check("awready", 64'(bus.s_axi_awready), 64'(exp_awready));
    check("wready",  64'(bus.s_axi_wready),  64'(exp_wready));
    check("arready", 64'(bus.s_axi_arready), 64'(exp_arready));
    check("bvalid",  64'(bus.s_axi_bvalid),  64'(exp_bvalid));
    check("rvalid",  64'(bus.s_axi_rvalid),  64'(exp_rvalid));
    check("wr_pulse", 64'(wr_pulse_o), 64'(exp_pulse));
    if (exp_bvalid) check("bresp", 64'(bus.s_axi_bresp), 64'(exp_bresp));
    if (exp_rvalid) begin
      check("rdata", 64'(bus.s_axi_rdata), 64'(exp_rdata));
      check("rresp", 64'(bus.s_axi_rresp), 64'(exp_rresp));
    end
    for (int i = 0; i < NUM_REGS; i++)
      check("regs_o", 64'(regs_o[i*DATA_W +: DATA_W]), 64'(mregs[i]));
    if (wr_pulse_o != 0) begin
      pulse_cnt++;
      last_pulse = wr_pulse_o;
    end
  end

  // Drivers: every task is entered on a negedge and returns on a negedge.
  task automatic drv_aw(input logic [8:0] addr, input int dly);
    int t = 0;
    repeat (dly) @(negedge clk);
    bus.s_axi_awaddr = addr; bus.s_axi_awvalid = 1'b1;
    while (!bus.s_axi_awready && t < TMO) begin @(negedge clk); t++; end
    if (t >= TMO) timeout("aw_handshake");
    @(negedge clk);
    bus.s_axi_awvalid = 1'b0;
  endtask

  task automatic drv_w(input logic [31:0] data, input logic [3:0] strb, input int dly);
    int t = 0;
    repeat (dly) @(negedge clk);
    bus.s_axi_wdata = data; bus.s_axi_wstrb = strb; bus.s_axi_wvalid = 1'b1;
    while (!bus.s_axi_wready && t < TMO) begin @(negedge clk); t++; end
    if (t >= TMO) timeout("w_handshake");
    @(negedge clk);
    bus.s_axi_wvalid = 1'b0;
  endtask

  task automatic do_write(input logic [8:0] addr, input logic [31:0] data, input logic [3:0] strb,
                          input int awd, input int wd, input int bd, output logic [1:0] resp);
    int t = 0;
    fork
      drv_aw(addr, awd);
      drv_w(data, strb, wd);
    join
    resp = 2'bxx;
    while (!bus.s_axi_bvalid && t < TMO) begin @(negedge clk); t++; end
    if (t >= TMO) begin timeout("bvalid"); return; end
    repeat (bd) @(negedge clk);
    resp = bus.s_axi_bresp;
    bus.s_axi_bready = 1'b1;
    @(negedge clk);
    bus.s_axi_bready = 1'b0;
  endtask

  task automatic do_read(input logic [8:0] addr, input int ard, input int rd,
                         output logic [31:0] data, output logic [1:0] resp);
    int t = 0;
    repeat (ard) @(negedge clk);
    bus.s_axi_araddr = addr; bus.s_axi_arvalid = 1'b1;
    while (!bus.s_axi_arready && t < TMO) begin @(negedge clk); t++; end
    if (t >= TMO) timeout("ar_handshake");
    @(negedge clk);
    bus.s_axi_arvalid = 1'b0;
    data = 'x; resp = 2'bxx; t = 0;
    while (!bus.s_axi_rvalid && t < TMO) begin @(negedge clk); t++; end
    if (t >= TMO) begin timeout("rvalid"); return; end
    repeat (rd) @(negedge clk);
    data = bus.s_axi_rdata; resp = bus.s_axi_rresp;
    bus.s_axi_rready = 1'b1;
    @(negedge clk);
    bus.s_axi_rready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0]  bresp_v, rresp_v;
    logic [31:0] rdata_v;
    int          pc0;

    bus.s_axi_awaddr = '0; bus.s_axi_awvalid = 0; bus.s_axi_wdata = '0; bus.s_axi_wstrb = '0;
    bus.s_axi_wvalid = 0; bus.s_axi_bready = 0; bus.s_axi_araddr = '0; bus.s_axi_arvalid = 0;
    bus.s_axi_rready = 0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("release_awready", 64'(bus.s_axi_awready), 64'd1);
    check("release_arready", 64'(bus.s_axi_arready), 64'd1);

    // Reset while a write response is pending.
    fork
      drv_aw(9'h00C, 0);
      drv_w(32'h12345678, 4'hF, 0);
    join
    begin
      int t = 0;
      while (!bus.s_axi_bvalid && t < TMO) begin @(negedge clk); t++; end
      if (t >= TMO) timeout("reset_bvalid");
    end
    #2 rst_n = 1'b0;
    #1;
    check("rst_bvalid", 64'(bus.s_axi_bvalid), 64'd0);
    check("rst_awready", 64'(bus.s_axi_awready), 64'd0);
    check("rst_wready", 64'(bus.s_axi_wready), 64'd0);
    check("rst_regs", 64'(regs_o[3*DATA_W +: DATA_W]), 64'd0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rerelease_awready", 64'(bus.s_axi_awready), 64'd1);
    check("rerelease_wready", 64'(bus.s_axi_wready), 64'd1);
    check("rerelease_arready", 64'(bus.s_axi_arready), 64'd1);

    // Full-word write to reg1.
    pc0 = pulse_cnt;
    do_write(9'h004, 32'hDEADBEEF, 4'hF, 0, 0, 0, bresp_v);
    check("t2_bresp", 64'(bresp_v), 64'd0);
    check("t2_reg1", 64'(regs_o[1*DATA_W +: DATA_W]), 64'hDEADBEEF);
    check("t2_pulse_cnt", 64'(pulse_cnt - pc0), 64'd1);
    check("t2_pulse", 64'(last_pulse), 64'b0010);

    // W ahead of AW, partial strobes.
    do_write(9'h008, 32'h11223344, 4'b0101, 3, 0, 0, bresp_v);
    check("t3_bresp", 64'(bresp_v), 64'd0);
    check("t3_reg2", 64'(regs_o[2*DATA_W +: DATA_W]), 64'h00220044);

    // Slow B acceptance, then a second write.
    do_write(9'h00C, 32'hA5A5A5A5, 4'hF, 0, 0, 5, bresp_v);
    check("t4_bresp", 64'(bresp_v), 64'd0);
    do_write(9'h00C, 32'h0000FFFF, 4'b0011, 0, 0, 0, bresp_v);
    check("t4_reg3", 64'(regs_o[3*DATA_W +: DATA_W]), 64'hA5A5FFFF);

    // Reads: held response, then out-of-range.
    do_read(9'h004, 0, 4, rdata_v, rresp_v);
    check("t5_rdata", 64'(rdata_v), 64'hDEADBEEF);
    check("t5_rresp", 64'(rresp_v), 64'd0);
    do_read(9'h010, 0, 0, rdata_v, rresp_v);
    check("t5_oor_rdata", 64'(rdata_v), 64'd0);
    check("t5_oor_rresp", 64'(rresp_v), 64'(ERR));
    pc0 = pulse_cnt;
    do_write(9'h014, 32'hFFFFFFFF, 4'hF, 0, 1, 0, bresp_v);
    check("t5_oor_bresp", 64'(bresp_v), 64'(ERR));
    check("t5_oor_nopulse", 64'(pulse_cnt - pc0), 64'd0);
    check("t5_reg1_kept", 64'(regs_o[1*DATA_W +: DATA_W]), 64'hDEADBEEF);

    // Read capture on the same edge as a write commit to the same register.
    fork
      do_write(9'h000, 32'h0000CAFE, 4'hF, 0, 0, 0, bresp_v);
      do_read(9'h000, 1, 0, rdata_v, rresp_v);
    join
    check("t6_old_value", 64'(rdata_v), 64'd0);
    do_read(9'h000, 0, 0, rdata_v, rresp_v);
    check("t6_new_value", 64'(rdata_v), 64'h0000CAFE);

    // Random concurrent traffic; addresses include out-of-range words and ignored low bits.
    for (int n = 0; n < 150; n++) begin
      logic [8:0]  wa, ra;
      logic [31:0] wdat;
      logic [3:0]  wst;
      int          mode;
      wa   = 9'(($urandom_range(0, 5) << 2) | $urandom_range(0, 3));
      ra   = 9'(($urandom_range(0, 5) << 2) | $urandom_range(0, 3));
      wdat = $urandom;
      wst  = 4'($urandom_range(0, 15));
      mode = $urandom_range(0, 2);
      fork
        if (mode != 1)
          do_write(wa, wdat, wst, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3), bresp_v);
        if (mode != 0)
          do_read(ra, $urandom_range(0, 3), $urandom_range(0, 3), rdata_v, rresp_v);
      join
    end
    repeat (3) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
